// File: rtl/digital_input_port.sv
// Single-bit memory-mapped input: pad synchronizer, optional debounce, edge-pending irq, registered read.
// Debounce filter is compiled in only when DIGITAL_INPUT_DEBOUNCE_EN is defined.
module digital_input_port #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pin_i,
  input  logic read_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic clear_i,
  output logic data_o,
  output logic level_o,
  output logic irq_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_irq;
  logic                   r_data;
  logic                   w_sync_s;
  logic                   w_level_nxt;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_set;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign w_sync_s = r_sync[SYNC_STAGES-1];

`ifdef DIGITAL_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_cnt_done;

  assign w_differs  = (w_sync_s != r_level);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Counter restarts on any agreeing sample, so a short glitch never accumulates.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (!w_differs || w_cnt_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_level_nxt = (w_differs && w_cnt_done) ? w_sync_s : r_level;
`else
  logic w_unused_debounce_cfg;

  assign w_unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
  assign w_level_nxt           = w_sync_s;
`endif

  // Edges come from next-state vs current level so irq sets on the same edge the level moves.
  assign w_rise = ~r_level &  w_level_nxt;
  assign w_fall =  r_level & ~w_level_nxt;
  assign w_set  = (w_rise & rise_en_i) | (w_fall & fall_en_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_level <= 1'b0;
      r_irq   <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_irq   <= w_set | (r_irq & ~clear_i);
      if (read_i) begin
        r_data <= r_level;
      end
    end
  end

  assign level_o = r_level;
  assign irq_o   = r_irq;
  assign data_o  = r_data;

endmodule

// File: tb/tb_digital_input_port.sv
// Bench for digital_input_port: window-based reference model checked every cycle, plus directed literal checks.
// Follows DIGITAL_INPUT_DEBOUNCE_EN the same way the design does.
module tb_digital_input_port;

  localparam int S = 2;
  localparam int D = 16;
`ifdef DIGITAL_INPUT_DEBOUNCE_EN
  localparam bit DB  = 1'b1;
  localparam int LAT = S + D - 1;
  localparam int GL  = 10;
`else
  localparam bit DB  = 1'b0;
  localparam int LAT = S;
  localparam int GL  = 3;
`endif

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic pin     = 1'b1;
  logic read    = 1'b0;
  logic rise_en = 1'b0;
  logic fall_en = 1'b0;
  logic clear   = 1'b0;
  logic data_o;
  logic level_o;
  logic irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  digital_input_port #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .pin_i     (pin),
    .read_i    (read),
    .rise_en_i (rise_en),
    .fall_en_i (fall_en),
    .clear_i   (clear),
    .data_o    (data_o),
    .level_o   (level_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  // Reference model: pin samples indexed by post-reset edge number.
  // The pre-edge synchronized value at edge n is the pin sampled at edge n-S.
  bit pin_q[$];
  bit m_level, m_irq, m_data;

  function automatic bit pv(int j);
    if (j < 1 || j > pin_q.size()) return 1'b0;
    return pin_q[j-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_q.delete();
      m_level = 1'b0;
      m_irq   = 1'b0;
      m_data  = 1'b0;
    end else begin
      int n;
      bit nl, all_diff;
      pin_q.push_back(pin);
      n = pin_q.size();
      if (DB) begin
        all_diff = 1'b1;
        for (int i = 0; i < D; i++)
          if (pv(n - S - i) == m_level) all_diff = 1'b0;
        nl = all_diff ? !m_level : m_level;
      end else begin
        nl = pv(n - S);
      end
      if (read) m_data = m_level;
      m_irq   = ((!m_level && nl && rise_en) || (m_level && !nl && fall_en)) || (m_irq && !clear);
      m_level = nl;
    end
  end

  always @(negedge clk) begin
    chk("cyc_level", level_o, m_level);
    chk("cyc_irq",   irq_o,   m_irq);
    chk("cyc_data",  data_o,  m_data);
  end

  int holds [11] = '{25, 5, 40, 2, 18, 1, 30, 16, 15, 17, 33};

  initial begin
    int cyc;
    // Reset with pin high: everything held at zero.
    rise_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_level", level_o, 1'b0);
    chk("rst_irq",   irq_o,   1'b0);
    chk("rst_data",  data_o,  1'b0);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("rst_rise_before", level_o, 1'b0);
    chk("rst_irq_before",  irq_o,   1'b0);
    @(negedge clk);
    chk("rst_rise_after", level_o, 1'b1);
    chk("rise_irq_same_edge", irq_o, 1'b1);

    // Clear the pending flag.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_irq", irq_o, 1'b0);

    // Read returns the high level next cycle.
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("read_high", data_o, 1'b1);

    // Falling level with fall_en off: no irq, data holds until next read.
    pin = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("fall_level", level_o, 1'b0);
    chk("fall_no_irq", irq_o, 1'b0);
    chk("data_holds", data_o, 1'b1);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("read_low", data_o, 1'b0);

    // Short pulse: rejected with debounce, propagates (and sets irq on fall) without.
    rise_en = 1'b0;
    fall_en = 1'b1;
    pin = 1'b1;
    repeat (GL) @(negedge clk);
    pin = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("pulse_level_end", level_o, 1'b0);
    chk("pulse_irq", irq_o, !DB);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("pulse_clear", irq_o, 1'b0);

    // Set/clear collision on the rising edge: set wins.
    rise_en = 1'b1;
    fall_en = 1'b0;
    pin = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("coll_level_before", level_o, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("coll_level_after", level_o, 1'b1);
    chk("coll_irq", irq_o, 1'b1);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_level", level_o, 1'b0);
    chk("async_rst_irq",   irq_o,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed pin pattern around the debounce threshold, model checks each cycle.
    cyc = 0;
    for (int idx = 0; idx < 11; idx++) begin
      pin = ~pin;
      for (int j = 0; j < holds[idx]; j++) begin
        read    = (cyc % 7 == 3);
        clear   = (cyc % 37 == 0);
        rise_en = (idx % 3 != 2);
        fall_en = (idx % 2 == 0);
        @(negedge clk);
        cyc++;
      end
    end
    read  = 1'b0;
    clear = 1'b0;
    pin   = 1'b0;
    repeat (LAT + 10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_input_port.md
Name: digital_input_port

Overview:
Memory-mapped single-bit general-purpose input for the board-level I/O bus; it is the read-side counterpart of the output latch port. An asynchronous pad signal passes through a synchronizer chain and an optional debounce filter to produce a stable level. The port detects rising and falling edges of that level, holds a sticky edge-pending interrupt flag, and returns the level on a registered bus read.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the metastability synchronizer chain; legal range 2..4.
DEBOUNCE_CYCLES, 16, consecutive identical synchronized samples required before the stable level changes; legal range 1..65535; used only when debounce is compiled in.

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
pin_i  input  1  raw pad input, asynchronous to clk_i, may bounce
read_i  input  1  bus read strobe, one cycle per access
rise_en_i  input  1  arm pending flag on rising edge of stable level
fall_en_i  input  1  arm pending flag on falling edge of stable level
clear_i  input  1  clear edge-pending flag
data_o  output  1  registered read data, last level captured by read_i
level_o  output  1  current stable (synchronized, debounced) level
irq_o  output  1  edge-pending interrupt flag, level-sensitive

Behaviour:
- Reset: all synchronizer stages, debounce counter, level_o, data_o and irq_o are 0. Assertion mid-operation clears everything immediately, with no clock required. First sampling occurs on the first rising edge after deassertion.
- Synchronizer: stage 1 samples pin_i; stage n samples stage n-1. sync_s is the last stage. If pin_i changes before edge k, sync_s reflects it after edge k+SYNC_STAGES-1.
- Debounce with DEBOUNCE_CYCLES = D and counter cnt, width clog2(D)+1, reset 0:
  - sync_s == level_o: cnt <= 0.
  - sync_s != level_o and cnt < D-1: cnt <= cnt+1.
  - sync_s != level_o and cnt == D-1: level_o <= sync_s, cnt <= 0.
  - A glitch shorter than D synchronized cycles resets cnt and never reaches level_o.
  - Latency: a clean pin change before edge k appears on level_o after edge k+SYNC_STAGES+D-1. For defaults this is edge k+17.
  - D = 1: level_o updates the cycle after sync_s differs.
- Edge detect:
  - rise = level_o changes 0->1 at this edge.
  - fall = level_o changes 1->0 at this edge.
  - Both are computed from the next-state value versus the current value, so irq_o is set on the same edge that level_o changes.
- Pending flag (irq_o):
  - Set when (rise & rise_en_i) | (fall & fall_en_i).
  - Cleared on the edge where clear_i = 1.
  - If set and clear occur at the same edge, set wins and irq_o stays 1.
  - Sticky: irq_o holds until cleared; further edges while pending have no additional effect.
  - Enables are sampled on the edge where level_o changes. Deasserting an enable does not clear an already-pending flag.
- Read: on an edge with read_i = 1, data_o <= level_o (the pre-edge value). data_o holds its value otherwise. Read has 1-cycle latency and does not affect irq_o.
- No other side effects; the port never back-pressures the bus.

Optional Feature:
DIGITAL_INPUT_DEBOUNCE_EN
- Defined: debounce counter present as described above; DEBOUNCE_CYCLES is honoured.
- Undefined: no counter is instantiated. level_o <= sync_s on every edge, giving pin-to-level latency of SYNC_STAGES edges (edge k+2 for defaults). DEBOUNCE_CYCLES is ignored. Edge detect, irq and read behaviour are unchanged.

Test Plan:
- Reset: drive pin_i=1 with rst_n_i=0, then deassert with defaults and debounce on -> data_o, level_o, irq_o = 0 during reset; level_o rises after edge 17 counted from the first post-reset edge.
- Glitch rejection: pin_i pulses 1 for 10 cycles from level 0, debounce on, D=16 -> level_o stays 0 and irq_o stays 0; cnt returns to 0.
- Rising-edge interrupt: rise_en_i=1, fall_en_i=0, pin_i 0->1 held 30 cycles -> irq_o=1 on the same edge level_o goes 1. A subsequent 1->0 transition leaves irq_o at 1; clear_i for one cycle then gives irq_o=0.
- Set/clear collision: clear_i asserted on the exact edge level_o rises with rise_en_i=1 -> irq_o=1 after that edge.
- Read path: level_o=1 and read_i pulsed -> data_o=1 the next cycle. Then pin falls and debounces while read_i=0 -> data_o stays 1 until the next read, which returns 0.
- Macro undefined: pin_i 0->1 before edge k -> level_o=1 after edge k+2. A 3-cycle pulse propagates to level_o and, with fall_en_i=1, sets irq_o.
